// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the entry type carried by the AddRoundKey output buffer.
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES256_NUM_RK = 15;
  localparam int AES128_NUM_RK = 11;

  // Sized for the largest key schedule (AES-256); narrower configurations zero-extend into it.
  localparam int ARK_DATA_W = AES_BLOCK_W;
  localparam int ARK_IDX_W  = $clog2(AES256_NUM_RK);

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } ark_count_e;

  typedef struct packed {
    logic [ARK_DATA_W-1:0] data;
    logic [ARK_IDX_W-1:0]  round;
    logic                  err;
  } ark_entry_t;

endpackage

// File: rtl/add_round_key_stage_if.sv
// Block stream into and out of the AddRoundKey stage.
interface add_round_key_stage_if #(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 4
);

  // Valid/ready: a transfer happens only on a rising edge with valid && ready both high.
  // A source holds valid and its payload stable until the transfer; valid never waits on ready.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_round;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_round;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_round, out_ready,
    input  in_ready, out_valid, out_data, out_round, out_err
  );

  modport slave (
    input  in_valid, in_data, in_round, out_ready,
    output in_ready, out_valid, out_data, out_round, out_err
  );

endinterface

// File: rtl/ark_skid_buf.sv
// Two-entry valid/ready buffer; full throughput with independent stalls on either side.
module ark_skid_buf
  import aes_pkg::*;
#(
  parameter type entry_t = ark_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  entry_t     in_entry,
  output logic       out_valid,
  input  logic       out_ready,
  output entry_t     out_entry,
  output ark_count_e state_dbg
);

  ark_count_e state, state_nxt;
  entry_t     head_q, tail_q;
  logic       push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CNT_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CNT_EMPTY: if (push) state_nxt = CNT_ONE;
      CNT_ONE: begin
        if (push && !pop)      state_nxt = CNT_FULL;
        else if (pop && !push) state_nxt = CNT_EMPTY;
      end
      CNT_FULL:  if (pop) state_nxt = CNT_ONE;
      default:   state_nxt = CNT_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state != CNT_FULL);
    out_valid = (state != CNT_EMPTY);
    out_entry = head_q;
    state_dbg = state;
  end

  // Head always drives the output; tail only holds the second block while FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state)
        CNT_EMPTY: if (push) head_q <= in_entry;
        CNT_ONE: begin
          if (push && pop) head_q <= in_entry;
          else if (push)   tail_q <= in_entry;
        end
        CNT_FULL:  if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey stage: round-key bank, XOR with the key picked by the block's round index, 2-entry output buffer.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter  int DATA_W   = AES_BLOCK_W,
  parameter  int NUM_KEYS = AES256_NUM_RK,
  localparam int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_wr_en,
  input  logic [IDX_W-1:0]    key_wr_idx,
  input  logic [DATA_W-1:0]   key_wr_data,
  output logic [NUM_KEYS-1:0] key_loaded,
  add_round_key_stage_if.slave bus,
  output ark_count_e          buf_state
);

  localparam logic [IDX_W:0] NUM_KEYS_EXT = (IDX_W+1)'(NUM_KEYS);

  logic [DATA_W-1:0] keys [NUM_KEYS];
  logic              wr_in_range, rd_in_range;
  logic [DATA_W-1:0] sel_key;
  logic              sel_err;
  ark_entry_t        push_entry, head_entry;

  assign wr_in_range = ({1'b0, key_wr_idx}   < NUM_KEYS_EXT);
  assign rd_in_range = ({1'b0, bus.in_round} < NUM_KEYS_EXT);

  // Nonblocking update gives read-before-write when a block and a key write hit the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) keys[i] <= '0;
      key_loaded <= '0;
    end else if (key_wr_en && wr_in_range) begin
      keys[key_wr_idx]       <= key_wr_data;
      key_loaded[key_wr_idx] <= 1'b1;
    end
  end

  always_comb begin
    sel_key = '0;
    sel_err = 1'b1;
    if (rd_in_range) begin
      sel_key = keys[bus.in_round];
      sel_err = !key_loaded[bus.in_round];
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.data  = ARK_DATA_W'(bus.in_data ^ sel_key);
    push_entry.round = ARK_IDX_W'(bus.in_round);
    push_entry.err   = sel_err;
  end

  ark_skid_buf #(.entry_t(ark_entry_t)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_entry  (push_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_entry (head_entry),
    .state_dbg (buf_state)
  );

  assign bus.out_data  = DATA_W'(head_entry.data);
  assign bus.out_round = IDX_W'(head_entry.round);
  assign bus.out_err   = head_entry.err;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: scenario tasks plus a scoreboard fed from a reference key-bank model.
module tb_add_round_key_stage;
  import aes_pkg::*;

  localparam int DW = 128;
  localparam int NK = 15;
  localparam int IW = 4;
  localparam int EW = DW + IW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              key_wr_en = 1'b0;
  logic [IW-1:0]     key_wr_idx = '0;
  logic [DW-1:0]     key_wr_data = '0;
  logic [NK-1:0]     key_loaded;
  ark_count_e        buf_state;

  add_round_key_stage_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  always #5 clk = ~clk;

  add_round_key_stage #(.DATA_W(DW), .NUM_KEYS(NK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .key_loaded  (key_loaded),
    .bus         (bus),
    .buf_state   (buf_state)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  int            popped = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model_key [16];
  logic          model_loaded [16];
  logic [EW-1:0] sb_exp, sb_got;
  logic [DW-1:0] sb_key;
  logic          sb_err;

  // Sampled on the falling edge, so it sees exactly what transfers at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
        model_key[i]    = '0;
        model_loaded[i] = 1'b0;
      end
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        sb_got = {bus.out_data, bus.out_round, bus.out_err};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected got %h with nothing expected", sb_got);
        end else begin
          sb_exp = exp_q.pop_front();
          popped++;
          if (sb_got !== sb_exp) begin
            errors++;
            $display("FAIL scoreboard_out got %h expected %h", sb_got, sb_exp);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_err = (bus.in_round >= NK) || !model_loaded[bus.in_round];
        sb_key = (bus.in_round >= NK) ? '0 : model_key[bus.in_round];
        exp_q.push_back({bus.in_data ^ sb_key, bus.in_round, sb_err});
      end
      if (key_wr_en && (key_wr_idx < NK)) begin
        model_key[key_wr_idx]    = key_wr_data;
        model_loaded[key_wr_idx] = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic write_key(input logic [IW-1:0] idx, input logic [DW-1:0] k);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = k;
    step();
    key_wr_en   = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] r);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_round = r;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout in_ready got 0 for 100 cycles required 1");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || bus.out_valid); i++) step();
    checks++;
    if (exp_q.size() != 0 || bus.out_valid) begin
      errors++;
      $display("FAIL drain_timeout pending %0d out_valid %b required 0 and 0", exp_q.size(), bus.out_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_in_reset got %b required 0", bus.out_valid); end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready); end
    checks++;
    if (key_loaded !== '0) begin errors++; $display("FAIL reset_key_loaded got %h required 0", key_loaded); end
    checks++;
    if ({bus.out_data, bus.out_round, bus.out_err} !== '0) begin
      errors++; $display("FAIL reset_out_payload got %h/%h/%b required all 0", bus.out_data, bus.out_round, bus.out_err);
    end
    checks++;
    if (buf_state !== CNT_EMPTY) begin errors++; $display("FAIL reset_buf_state got %0d required 0", buf_state); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d;
    exp_d = 128'h00102030405060708090a0b0c0d0e0f0;
    bus.out_ready = 1'b1;
    write_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    send(128'h00112233445566778899aabbccddeeff, 4'd0);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b required 1", bus.out_valid); end
    checks++;
    if (bus.out_data !== exp_d) begin errors++; $display("FAIL basic_out_data got %h required %h", bus.out_data, exp_d); end
    checks++;
    if (bus.out_err !== 1'b0) begin errors++; $display("FAIL basic_out_err got %b required 0", bus.out_err); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int p0;
    for (int i = 0; i < NK; i++) write_key(IW'(i), rand_block());
    checks++;
    if (key_loaded !== 15'h7fff) begin errors++; $display("FAIL b2b_key_loaded got %h required 7fff", key_loaded); end
    bus.out_ready = 1'b1;
    p0 = popped;
    for (int i = 0; i < NK; i++) begin
      send(rand_block(), IW'(i));
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready block %0d got %b required 1", i, bus.in_ready); end
    end
    wait_drain();
    checks++;
    if (popped - p0 != NK) begin errors++; $display("FAIL b2b_count got %0d required %0d", popped - p0, NK); end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] snap, head_exp;
    logic          acc;
    bus.out_ready = 1'b0;
    send(rand_block(), 4'd1);
    send(rand_block(), 4'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = rand_block();
    bus.in_round = 4'd3;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b required 0", bus.in_ready); end
    head_exp = exp_q[0];
    snap = {bus.out_data, bus.out_round, bus.out_err};
    checks++;
    if (snap !== head_exp) begin errors++; $display("FAIL bp_head got %h required %h", snap, head_exp); end
    repeat (3) step();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_held got %b required 0", bus.in_ready); end
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_round, bus.out_err} !== {1'b1, head_exp}) begin
      errors++; $display("FAIL bp_stable got %b/%h required 1/%h", bus.out_valid, {bus.out_data, bus.out_round, bus.out_err}, head_exp);
    end
    bus.out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL bp_third_accept got 0 required 1"); end
    wait_drain();
  endtask

  task automatic test_errors();
    logic [DW-1:0] d;
    apply_reset();
    bus.out_ready = 1'b1;
    write_key(4'd15, rand_block());
    checks++;
    if (key_loaded !== '0) begin errors++; $display("FAIL err_bad_write got %h required 0", key_loaded); end
    d = rand_block();
    send(d, 4'd15);
    checks++;
    if ({bus.out_data, bus.out_round, bus.out_err} !== {d, 4'd15, 1'b1}) begin
      errors++; $display("FAIL err_round15 got %h/%h/%b required %h/f/1", bus.out_data, bus.out_round, bus.out_err, d);
    end
    wait_drain();
    d = rand_block();
    send(d, 4'd7);
    checks++;
    if ({bus.out_data, bus.out_err} !== {d, 1'b1}) begin
      errors++; $display("FAIL err_unloaded got %h/%b required %h/1", bus.out_data, bus.out_err, d);
    end
    wait_drain();
    write_key(4'd7, 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f);
    checks++;
    if (key_loaded !== 15'h0080) begin errors++; $display("FAIL err_loaded7 got %h required 0080", key_loaded); end
    send(128'hffffffff_ffffffff_ffffffff_ffffffff, 4'd7);
    checks++;
    if ({bus.out_data, bus.out_err} !== {128'hf0f0f0f0_f0f0f0f0_f0f0f0f0_f0f0f0f0, 1'b0}) begin
      errors++; $display("FAIL err_slot7_ok got %h/%b required f0..f0/0", bus.out_data, bus.out_err);
    end
    wait_drain();
  endtask

  task automatic test_same_slot();
    logic [DW-1:0] k1, k2, d1, d2;
    k1 = rand_block(); k2 = rand_block(); d1 = rand_block(); d2 = rand_block();
    bus.out_ready = 1'b1;
    write_key(4'd3, k1);
    key_wr_en    = 1'b1;
    key_wr_idx   = 4'd3;
    key_wr_data  = k2;
    bus.in_valid = 1'b1;
    bus.in_data  = d1;
    bus.in_round = 4'd3;
    step();
    key_wr_en    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data !== (d1 ^ k1)) begin errors++; $display("FAIL same_slot_old got %h required %h", bus.out_data, d1 ^ k1); end
    send(d2, 4'd3);
    checks++;
    if (bus.out_data !== (d2 ^ k2)) begin errors++; $display("FAIL same_slot_new got %h required %h", bus.out_data, d2 ^ k2); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(rand_block(), 4'd3);
    send(rand_block(), 4'd7);
    checks++;
    if (buf_state !== CNT_FULL) begin errors++; $display("FAIL mid_full got %0d required 2", buf_state); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b required 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b required 1", bus.in_ready); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d out_valid %b required 0", i, bus.out_valid); end
    end
    checks++;
    if (key_loaded !== '0) begin errors++; $display("FAIL mid_key_loaded got %h required 0", key_loaded); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_round  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_same_slot();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
